// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing with a
// variable-latency memory handshake, prioritised interrupts and a registered trap cause.
module multicycle_control #(
    parameter int IRQ_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             ker,
    input  logic [IRQ_N-1:0] irq,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             PCWrite,
    output logic [2:0]       PCSrc,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic             ALUSrc1,
    output logic             ALUSrc2,
    output logic             ExtOp,
    output logic             LuOp,
    output logic             sign,
    output logic [5:0]       ALUFun,
    output logic [IRQ_N-1:0] irq_ack,
    output logic [4:0]       cause,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_fetch_first;
    logic [4:0]       r_cause;
    logic [IRQ_N-1:0] r_irq_ack;

    logic [IRQ_N:0]   w_irq_below;
    logic [IRQ_N-1:0] w_irq_onehot;
    logic [3:0]       w_irq_idx;
    logic             w_irq_take;
    logic             w_rtype, w_rtype_legal, w_legal;
    logic             w_branch, w_j, w_jal, w_jr, w_jalr, w_load, w_store;
    logic [5:0]       w_alufun;

    // Lowest-index request wins: each line is masked by any lower line.
    assign w_irq_below[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_prio
            assign w_irq_below[gi+1] = w_irq_below[gi] | irq[gi];
            assign w_irq_onehot[gi]  = irq[gi] & ~w_irq_below[gi];
        end
    endgenerate

    always_comb begin
        w_irq_idx = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (w_irq_onehot[i]) w_irq_idx = w_irq_idx | 4'(i);
        end
    end

    assign w_irq_take = (r_state == S_FETCH) && r_fetch_first && w_irq_below[IRQ_N] && !ker;

    assign w_rtype  = (OpCode == 6'h00);
    assign w_branch = (OpCode == 6'h01) || (OpCode inside {[6'h04:6'h07]});
    assign w_j      = (OpCode == 6'h02);
    assign w_jal    = (OpCode == 6'h03);
    assign w_jr     = w_rtype && (Funct == 6'h08);
    assign w_jalr   = w_rtype && (Funct == 6'h09);
    assign w_load   = (OpCode == 6'h23);
    assign w_store  = (OpCode == 6'h2B);

    always_comb begin
        w_rtype_legal = Funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2A};
        w_legal       = w_rtype ? w_rtype_legal
                                : (OpCode inside {[6'h01:6'h0C], 6'h0F, 6'h23, 6'h2B});
    end

    always_comb begin
        w_alufun = 6'b000000;
        if (w_rtype) begin
            case (Funct)
                6'h22, 6'h23: w_alufun = 6'b000001;
                6'h24:        w_alufun = 6'b011000;
                6'h25:        w_alufun = 6'b011110;
                6'h26:        w_alufun = 6'b010110;
                6'h27:        w_alufun = 6'b010001;
                6'h2A:        w_alufun = 6'b110101;
                6'h00:        w_alufun = 6'b100000;
                6'h02:        w_alufun = 6'b100001;
                6'h03:        w_alufun = 6'b100011;
                default:      w_alufun = 6'b000000;
            endcase
        end else begin
            case (OpCode)
                6'h0C:        w_alufun = 6'b011000;
                6'h0F:        w_alufun = 6'b011010;
                6'h0A, 6'h0B: w_alufun = 6'b110101;
                6'h04:        w_alufun = 6'b110011;
                6'h05:        w_alufun = 6'b110001;
                6'h06:        w_alufun = 6'b111101;
                6'h07:        w_alufun = 6'b111011;
                6'h01:        w_alufun = 6'b111111;
                default:      w_alufun = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_fetch_first <= 1'b1;
            r_cause       <= 5'd0;
            r_irq_ack     <= '0;
        end else begin
            r_irq_ack     <= '0;
            r_fetch_first <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (w_irq_take) begin
                        r_state   <= S_TRAP;
                        r_irq_ack <= w_irq_onehot;
                        r_cause   <= {1'b0, w_irq_idx};
                    end else if (mem_ready) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                        r_cause <= 5'b10000;
                    end
                end
                S_EXEC: begin
                    if (w_branch || w_j || w_jal || w_jr || w_jalr) begin
                        r_state       <= S_FETCH;
                        r_fetch_first <= 1'b1;
                    end else if (w_load || w_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_state       <= w_load ? S_WB : S_FETCH;
                        r_fetch_first <= !w_load;
                    end
                end
                default: begin
                    r_state       <= S_FETCH;
                    r_fetch_first <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 3'd0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 2'd0;
        ALUSrc1  = 1'b0;
        ALUSrc2  = 1'b0;
        ExtOp    = 1'b0;
        LuOp     = 1'b0;
        sign     = 1'b0;
        ALUFun   = 6'b000000;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    if (!w_irq_take) begin
                        MemRead = 1'b1;
                        IRWrite = mem_ready;
                        PCWrite = mem_ready;
                    end
                end
                S_EXEC: begin
                    ALUSrc1 = w_rtype && (Funct inside {6'h00, 6'h02, 6'h03});
                    ALUSrc2 = (OpCode >= 6'h08);
                    ExtOp   = OpCode inside {6'h01, [6'h04:6'h08], 6'h0A, 6'h23, 6'h2B};
                    LuOp    = (OpCode == 6'h0F);
                    sign    = (OpCode != 6'h0B);
                    ALUFun  = w_alufun;
                    if (w_branch) begin
                        PCWrite = br_taken;
                        PCSrc   = 3'd1;
                    end else if (w_j || w_jal) begin
                        PCWrite  = 1'b1;
                        PCSrc    = 3'd2;
                        RegWrite = w_jal;
                        RegDst   = w_jal ? 2'd2 : 2'd0;
                        MemtoReg = w_jal ? 2'd2 : 2'd0;
                    end else if (w_jr || w_jalr) begin
                        PCWrite  = 1'b1;
                        PCSrc    = 3'd3;
                        RegWrite = w_jalr;
                        MemtoReg = w_jalr ? 2'd2 : 2'd0;
                    end
                end
                S_MEM: begin
                    MemRead  = w_load;
                    MemWrite = w_store;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = w_rtype ? 2'd0 : 2'd1;
                    MemtoReg = w_load ? 2'd1 : 2'd0;
                end
                S_TRAP: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd3;
                    MemtoReg = 2'd2;
                    PCWrite  = 1'b1;
                    PCSrc    = r_cause[4] ? 3'd5 : 3'd4;
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign cause   = r_cause;
    assign irq_ack = r_irq_ack;
endmodule
